// File: rtl/mem_axi_bridge_pkg.sv
// mem_axi_pkg: shared state encoding and AXI constants for the CPU-to-DDR bridge
// Contents: state_t (bridge FSM states), AXI attribute constants, cache-line size.
package mem_axi_pkg;
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RESP} state_t;
    localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE      = 4'b0011;
    localparam int         LINE_BYTES     = 64;
endpackage

// File: rtl/mem_axi_bridge_if.sv
// mem_axi_bridge_if: AXI4 link between the bridge (master) and the DDR controller port (slave)
// Params: ADDR_W byte-address width.
// Signals: aw*/w*/b*/ar*/r* channels, 512-bit data, 64-bit strobes, 4-bit ids.
interface mem_axi_bridge_if #(parameter int ADDR_W = 31);
    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic              awvalid;
    logic              awready;
    logic [511:0]      wdata;
    logic [63:0]       wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [511:0]      rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/mem_axi_bridge_lane_sel.sv
// mem_lane_sel: 32-bit word lane extract from a 512-bit line and 4->64 byte-strobe placement
// Ports: data (line), lane (word index 0..15), strb (word byte enables)
//        -> word (selected word), strb_line (strobes shifted to the lane).
module mem_lane_sel (
    input  logic [511:0] data,
    input  logic [3:0]   lane,
    input  logic [3:0]   strb,
    output logic [31:0]  word,
    output logic [63:0]  strb_line
);
    assign word      = data[{lane, 5'b0} +: 32];
    assign strb_line = {60'b0, strb} << {lane, 2'b00};
endmodule

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: single-outstanding bridge from a 32-bit CPU load/store port to a 512-bit AXI4 slave
// Ports: clk, rst (async, active-high); req_* CPU request (valid/ready, we, addr, wdata, wstrb);
//        resp_* one-cycle completion (valid, rdata, err); s_axi AXI4 master to the DDR controller.
module mem_axi_bridge
    import mem_axi_pkg::*;
#(
    parameter int ADDR_W = 31,
    parameter int AXI_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    mem_axi_bridge_if.master  s_axi
);
    localparam int OFF_W = $clog2(LINE_BYTES);

    state_t            state, nxt;
    logic [ADDR_W-1:0] line;
    logic [3:0]        lane, strb;
    logic [31:0]       wd, word;
    logic [63:0]       strb_line;
    logic              got, accept, unused;

    mem_lane_sel u_sel (
        .data      (s_axi.rdata),
        .lane      (lane),
        .strb      (strb),
        .word      (word),
        .strb_line (strb_line)
    );

    // Word-offset bits, ids and the low response bit carry nothing the bridge acts on.
    assign unused    = ^{req_addr[1:0], s_axi.bid, s_axi.rid, s_axi.bresp[0], s_axi.rresp[0]};
    assign req_ready = state == IDLE && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = accept ? (req_we ? AW : AR) : IDLE;
            AW:      nxt = s_axi.awready ? W : AW;
            W:       nxt = s_axi.wready ? B : W;
            B:       nxt = s_axi.bvalid ? RESP : B;
            AR:      nxt = s_axi.arready ? R : AR;
            R:       nxt = (s_axi.rvalid && s_axi.rlast) ? RESP : R;
            default: nxt = IDLE;
        endcase
    end

    // Only the first read beat is kept; any trailing beats are drained until rlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line       <= '0;
            lane       <= '0;
            strb       <= '0;
            wd         <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            got        <= 1'b0;
        end else if (accept) begin
            line       <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            lane       <= req_addr[5:2];
            strb       <= req_wstrb;
            wd         <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            got        <= 1'b0;
        end else if (state == B && s_axi.bvalid) begin
            resp_err   <= s_axi.bresp[1];
        end else if (state == R && s_axi.rvalid && !got) begin
            resp_rdata <= word;
            resp_err   <= s_axi.rresp[1];
            got        <= 1'b1;
        end
    end

    assign resp_valid    = state == RESP;
    assign s_axi.awvalid = state == AW;
    assign s_axi.wvalid  = state == W;
    assign s_axi.wlast   = state == W;
    assign s_axi.bready  = state == B;
    assign s_axi.arvalid = state == AR;
    assign s_axi.rready  = state == R;
    assign s_axi.awaddr  = line;
    assign s_axi.araddr  = line;
    assign s_axi.wdata   = {16{wd}};
    assign s_axi.wstrb   = strb_line;

    assign s_axi.awid    = 4'(AXI_ID);
    assign s_axi.awlen   = 8'd0;
    assign s_axi.awsize  = AXI_SIZE_64B;
    assign s_axi.awburst = AXI_BURST_INCR;
    assign s_axi.awlock  = 1'b0;
    assign s_axi.awcache = AXI_CACHE;
    assign s_axi.awprot  = 3'd0;
    assign s_axi.awqos   = 4'd0;
    assign s_axi.arid    = 4'(AXI_ID);
    assign s_axi.arlen   = 8'd0;
    assign s_axi.arsize  = AXI_SIZE_64B;
    assign s_axi.arburst = AXI_BURST_INCR;
    assign s_axi.arlock  = 1'b0;
    assign s_axi.arcache = AXI_CACHE;
    assign s_axi.arprot  = 3'd0;
    assign s_axi.arqos   = 4'd0;
endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge: self-checking bench for mem_axi_bridge with an AXI slave model and word-level reference memory
module tb_mem_axi_bridge;
    localparam int ADDR_W = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [30:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int          n_chk = 0, n_fail = 0;

    mem_axi_bridge_if #(.ADDR_W(ADDR_W)) axi ();

    mem_axi_bridge #(.ADDR_W(ADDR_W), .AXI_ID(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .s_axi      (axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- AXI slave model ----------------
    function automatic logic [511:0] ramp();
        logic [511:0] v = '0;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = 32'(i);
        return v;
    endfunction

    function automatic logic [511:0] merge(input logic [511:0] old, input logic [511:0] d, input logic [63:0] s);
        logic [511:0] v = old;
        for (int i = 0; i < 64; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    // Lines are indexed by address bits [12:6]; the bench keeps its lines in distinct slots.
    logic [511:0] smem [128] = '{1: ramp(), default: '0};
    int           aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0, r_extra = 0;
    logic [1:0]   b_code = 2'b00, r_code = 2'b00;
    int           aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, r_left, r_beat;
    logic         b_pend, r_pend;
    logic [30:0]  aw_a;
    logic [511:0] r_line;

    assign axi.awready = axi.awvalid && aw_cnt >= aw_dly;
    assign axi.wready  = axi.wvalid && w_cnt >= w_dly;
    assign axi.arready = axi.arvalid && ar_cnt >= ar_dly;
    assign axi.bvalid  = b_pend && b_cnt >= b_dly;
    assign axi.bresp   = b_code;
    assign axi.bid     = '0;
    assign axi.rvalid  = r_pend && r_cnt >= r_dly;
    assign axi.rlast   = r_left == 0;
    assign axi.rdata   = r_beat == 0 ? r_line : ~r_line;
    assign axi.rresp   = r_beat == 0 ? r_code : 2'b00;
    assign axi.rid     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            r_left <= 0; r_beat <= 0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_a <= '0; r_line <= '0;
        end else begin
            aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
            if (axi.awvalid && axi.awready) aw_a <= axi.awaddr;
            if (axi.wvalid && axi.wready) begin
                smem[aw_a[12:6]] <= merge(smem[aw_a[12:6]], axi.wdata, axi.wstrb);
                b_pend <= 1'b1;
                b_cnt  <= 0;
            end else if (axi.bvalid && axi.bready) b_pend <= 1'b0;
            else if (b_pend && !axi.bvalid) b_cnt <= b_cnt + 1;
            if (axi.arvalid && axi.arready) begin
                r_pend <= 1'b1;
                r_cnt  <= 0;
                r_left <= r_extra;
                r_beat <= 0;
                r_line <= smem[axi.araddr[12:6]];
            end else if (axi.rvalid && axi.rready) begin
                if (r_left == 0) r_pend <= 1'b0;
                else begin
                    r_left <= r_left - 1;
                    r_beat <= r_beat + 1;
                end
            end else if (r_pend && !axi.rvalid) r_cnt <= r_cnt + 1;
        end
    end

    // ---------------- Handshake monitor and AXI stability checks ----------------
    logic [30:0]  got_awaddr = '0, got_araddr = '0, h_awaddr = '0, h_araddr = '0;
    logic [511:0] got_wdata = '0, h_wdata = '0;
    logic [63:0]  got_wstrb = '0, h_wstrb = '0;
    logic         got_wlast = 1'b0, p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if (p_aw) chk("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, h_awaddr});
            if (p_w)  chk("w_hold", {axi.wvalid, axi.wstrb, axi.wdata}, {1'b1, h_wstrb, h_wdata});
            if (p_ar) chk("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, h_araddr});
            p_aw <= axi.awvalid && !axi.awready;
            p_w  <= axi.wvalid && !axi.wready;
            p_ar <= axi.arvalid && !axi.arready;
            h_awaddr <= axi.awaddr; h_wdata <= axi.wdata; h_wstrb <= axi.wstrb; h_araddr <= axi.araddr;
            if (axi.awvalid && axi.awready) got_awaddr <= axi.awaddr;
            if (axi.arvalid && axi.arready) got_araddr <= axi.araddr;
            if (axi.wvalid && axi.wready) begin
                got_wdata <= axi.wdata;
                got_wstrb <= axi.wstrb;
                got_wlast <= axi.wlast;
            end
        end
    end

    // ---------------- Reference model: CPU-visible word memory ----------------
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_word(input logic [30:0] a);
        int unsigned k = int'(a) / 4;
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    function automatic logic [30:0] exp_line(input logic [30:0] a);
        return a - (a % 64);
    endfunction

    function automatic logic [63:0] exp_strb(input logic [30:0] a, input logic [3:0] s);
        return 64'(s) << (4 * (int'(a % 64) / 4));
    endfunction

    task automatic do_req(input logic we, input logic [30:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er, output int lat);
        int   t = 0;
        logic busy_rdy = 1'b0;
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            busy_rdy |= req_ready;
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        chk("req_ready_busy", busy_rdy, 1'b0);
        chk("resp_seen", resp_valid, 1'b1);
        @(negedge clk);
        chk("resp_one_pulse", {resp_valid, req_ready}, 2'b01);
    endtask

    task automatic txn(input logic we, input logic [30:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er, output int lat);
        logic [31:0] w;
        do_req(we, a, d, s, rd, er, lat);
        if (we) begin
            w = ref_word(a);
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[int'(a) / 4] = w;
        end
    endtask

    typedef struct {
        logic        we;
        logic [30:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [30:0] line;
        logic [63:0] wstrb;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, we;
        logic [30:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          lat, exp_lat, t;

        for (int i = 0; i < 16; i++) ref_mem[32'h40 / 4 + i] = 32'(i);
        vt[0] = '{1'b1, 31'h44,       32'hDEADBEEF, 4'hF,    31'h40,       64'hF0,                  32'h0,        4};
        vt[1] = '{1'b0, 31'h7C,       32'h0,        4'h0,    31'h40,       64'h0,                   32'hF,        3};
        vt[2] = '{1'b1, 31'h1008,     32'h11AA2233, 4'b0100, 31'h1000,     64'h400,                 32'h0,        4};
        vt[3] = '{1'b0, 31'h1008,     32'h0,        4'h0,    31'h1000,     64'h0,                   32'h00AA0000, 3};
        vt[4] = '{1'b0, 31'h44,       32'h0,        4'h0,    31'h40,       64'h0,                   32'hDEADBEEF, 3};
        vt[5] = '{1'b1, 31'h7FFFFFFC, 32'h12345678, 4'b1001, 31'h7FFFFFC0, 64'h9000_0000_0000_0000, 32'h0,        4};
        vt[6] = '{1'b0, 31'h7FFFFFFF, 32'h0,        4'h0,    31'h7FFFFFC0, 64'h0,                   32'h12000078, 3};

        // Reset state, including the constant AXI attributes.
        repeat (2) @(negedge clk);
        chk("rst_cpu", {req_ready, resp_valid, resp_err, resp_rdata}, '0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, '0);
        chk("rst_bus", {axi.awaddr, axi.araddr, axi.wstrb, axi.wdata}, '0);
        chk("rst_aw_const", {axi.awid, axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.awlock, axi.awprot, axi.awqos},
            {4'h0, 8'h0, 3'b110, 2'b01, 4'b0011, 1'b0, 3'h0, 4'h0});
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1'b1);

        // Directed vectors with all slave readies immediate.
        for (int i = 0; i < 7; i++) begin
            txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), er, 1'b0);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
            if (vt[i].we) begin
                chk($sformatf("vec%0d_awaddr", i), got_awaddr, vt[i].line);
                chk($sformatf("vec%0d_wstrb", i), got_wstrb, vt[i].wstrb);
                chk($sformatf("vec%0d_wdata", i), got_wdata, {16{vt[i].wdata}});
                chk($sformatf("vec%0d_wlast", i), got_wlast, 1'b1);
            end else chk($sformatf("vec%0d_araddr", i), got_araddr, vt[i].line);
        end

        // Backpressure on every store channel.
        aw_dly = 5; w_dly = 3; b_dly = 7;
        txn(1'b1, 31'h2004, 32'hCAFEF00D, 4'hF, rd, er, lat);
        chk("bp_lat", lat, 19);
        chk("bp_err", er, 1'b0);
        chk("bp_wstrb", got_wstrb, 64'hF0);
        aw_dly = 0; w_dly = 0; b_dly = 0;
        txn(1'b0, 31'h2004, 32'h0, 4'h0, rd, er, lat);
        chk("bp_readback", rd, 32'hCAFEF00D);

        // Multi-beat read: only the first beat is returned, the rest drained until rlast.
        r_dly = 2; r_extra = 2;
        txn(1'b0, 31'h7C, 32'h0, 4'h0, rd, er, lat);
        chk("burst_rdata", rd, 32'hF);
        chk("burst_lat", lat, 7);
        r_dly = 0; r_extra = 0;

        // Error responses are reported, then cleared by the next good access.
        b_code = 2'b10;
        txn(1'b1, 31'h1010, 32'h55, 4'h1, rd, er, lat);
        chk("err_store", er, 1'b1);
        b_code = 2'b00; r_code = 2'b11;
        txn(1'b0, 31'h1008, 32'h0, 4'h0, rd, er, lat);
        chk("err_load", er, 1'b1);
        chk("err_load_rdata", rd, 32'h00AA0000);
        r_code = 2'b00;
        txn(1'b0, 31'h1010, 32'h0, 4'h0, rd, er, lat);
        chk("err_cleared", er, 1'b0);
        chk("err_store_data", rd, 32'h55);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            a = 31'h2100 + 31'($urandom_range(0, 255));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); r_extra = $urandom_range(0, 2);
            b_code = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            r_code = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
            exp_rd  = we ? 32'h0 : ref_word(a);
            exp_er  = we ? b_code[1] : r_code[1];
            exp_lat = we ? 4 + aw_dly + w_dly + b_dly : 3 + ar_dly + r_dly + r_extra;
            txn(we, a, d, s, rd, er, lat);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_err", er, exp_er);
            chk("rnd_lat", lat, exp_lat);
            if (we) begin
                chk("rnd_awaddr", got_awaddr, exp_line(a));
                chk("rnd_wstrb", got_wstrb, exp_strb(a, s));
                chk("rnd_wdata", got_wdata, {16{d}});
            end else chk("rnd_araddr", got_araddr, exp_line(a));
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; r_extra = 0;
        b_code = 2'b00; r_code = 2'b00;

        // Asynchronous reset while a store sits in the W phase.
        w_dly = 20;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 31'h2040; req_wdata = 32'h77; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!axi.wvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("midw_wvalid", axi.wvalid, 1'b1);
        #2 rst = 1'b1;
        #1 chk("midw_async", {axi.wvalid, axi.awvalid, req_ready}, 3'b000);
        t = 0;
        repeat (2) begin
            @(negedge clk);
            t += int'(resp_valid);
        end
        rst = 1'b0;
        w_dly = 0;
        repeat (2) begin
            @(negedge clk);
            t += int'(resp_valid);
        end
        chk("midw_no_resp", t, 0);
        txn(1'b0, 31'h44, 32'h0, 4'h0, rd, er, lat);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_ar_const", {axi.arid, axi.arlen, axi.arsize, axi.arburst, axi.arcache, axi.arlock, axi.arprot, axi.arqos},
            {4'h0, 8'h0, 3'b110, 2'b01, 4'b0011, 1'b0, 3'h0, 4'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_axi_bridge.md
Name: mem_axi_bridge

Overview:
- Single-outstanding bridge from the CPU core's 32-bit word load/store port to the 512-bit AXI4 slave port of the DDR memory controller.
- Each CPU request becomes exactly one single-beat AXI transaction on the 64-byte line that contains the addressed word.
- Sits directly upstream of the memory controller and replaces the bring-up memory tester on that port.

Parameters:
- ADDR_W, 31, AXI byte-address width; matches the controller port.
- AXI_ID, 0, constant value driven on arid/awid.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_wstrb  in  4  store byte enables
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  32  load data; 0 for stores
- resp_err  out  1  AXI SLVERR/DECERR seen (resp[1])
- s_axi_aw*/w*/b*/ar*/r*  AXI4 master side, widths per controller: addr ADDR_W, data 512, strb 64, id 4, len 8, size 3, burst 2, cache 4, prot 3, qos 4, lock 1.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; req_ready=0; resp_valid=0; resp_rdata=0; resp_err=0.
  - All AXI valid/ready outputs 0; addr, data and strb outputs 0.
  - Constants hold in and out of reset: len=0, size=3'b110 (64 B), burst=INCR, cache=4'b0011, lock/prot/qos=0, id=AXI_ID.
- Reset mid-transaction abandons it immediately with no response; the controller is reset alongside.
- req_ready=1 only in IDLE. A request is accepted on req_valid & req_ready; req_ready drops the next cycle.
- Captured at accept: line address = {req_addr[ADDR_W-1:6], 6'b0}; lane = req_addr[5:2].
- Store path:
  - IDLE -> AW: awvalid=1, awaddr=line address. Hold until awready.
  - AW -> W: wvalid=1, wlast=1, wdata = req_wdata replicated 16x, wstrb = req_wstrb << (4*lane), all other strb bits 0. Hold until wready.
  - W -> B: bready=1; wait for bvalid. Capture err = bresp[1].
  - B -> RESP.
- Load path:
  - IDLE -> AR: arvalid=1, araddr=line address. Hold until arready.
  - AR -> R: rready=1; wait for rvalid.
  - Capture rdata[32*lane +: 32] and rresp[1] on the first beat.
  - If rlast=0, keep rready high and discard further beats until rlast. Exit R on rvalid & rlast.
- RESP: resp_valid=1 for exactly one cycle with captured data/err, then IDLE with req_ready=1 the next cycle.
- Minimum latency, accept to resp_valid, with slave ready signals tied high:
  - Store: 4 cycles (AW, W, B, RESP).
  - Load: 3 cycles (AR, R, RESP).
- AXI rules:
  - No valid is withdrawn before its handshake.
  - awaddr/wdata/araddr are stable while valid.
  - Never more than one transaction outstanding.
- Errors are reported but do not change sequencing; resp_err clears at the next accept.
- Unexpected bvalid/rvalid outside B/R is ignored (ready is low).

Decomposition:
- Shared package mem_axi_pkg:
  - state enum (IDLE, AW, W, B, AR, R, RESP).
  - Constants: AXI_SIZE_64B=3'b110, AXI_BURST_INCR=2'b01, AXI_CACHE=4'b0011, LINE_BYTES=64.
- One natural sub-module, mem_lane_sel: combinational 512->32 lane extract plus 4->64 strobe shift, reused by the future cache refill path.

Test Plan:
- Store 0xDEADBEEF, addr 0x00000044, strb 4'hF, all readies high -> awaddr=0x40; wstrb=0x0000_0000_0000_00F0; resp_valid exactly 4 cycles after accept; resp_err=0.
- Load addr 0x0000007C after the slave model holds line 0x40 with word i = i -> araddr=0x40; resp_rdata=0x0000000F; latency 3 cycles.
- Byte store strb 4'b0100, addr 0x0000_1008 -> wstrb bit 10 set only; a following load of 0x1008 returns the byte in [23:16].
- Backpressure: awready held low 5 cycles, wready low 3, bvalid delayed 7 -> valids stay asserted and stable; exactly one resp_valid pulse; req_ready stays 0 throughout.
- Error: bresp=2'b10 on a store, then rresp=2'b11 on a load -> resp_err=1 on both responses; a third good load -> resp_err=0.
- Assert rst while in W with wvalid=1 -> wvalid=0 and req_ready=0 in the same cycle (async); no resp_valid; after release, IDLE accepts a new request.
